uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- 8N1 UART receiver that deserialises the board UART_TXD_IN line into bytes for the CPU's memory-mapped UART peripheral.
- Sits directly behind the top-level pin, ahead of the UART register/bus interface.
- The register interface consumes bytes through a valid/ready handshake.
- The block holds one byte and reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 10416 at defaults): clocks per bit. May be overridden directly, e.g. 16 for fast simulation. Must be >= 4; elaboration-time check.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte completed while the holding register was still full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst.
- Synchroniser: 2-FF on rxd, giving rxd_s; both flops reset to 1. All decisions use rxd_s only.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. State=IDLE, bit counter=0, clock counter=0.
- rst mid-frame aborts the frame with no pulses. After reset the FSM needs rxd_s high before a new start can be detected, because the synchroniser is reset to 1.
- HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: when rxd_s==0, go to START and clear the clock counter.
- START: count to HALF-1.
  - At HALF-1, if rxd_s==0, go to DATA with counters cleared.
  - Otherwise treat it as a glitch and return to IDLE. No output effect.
- DATA: count to CLKS_PER_BIT-1.
  - At terminal count, shift in LSB first: shreg <= {rxd_s, shreg[7:1]}.
  - Increment the bit index. After the 8th sample go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rxd_s.
  - rxd_s==1: deliver the byte and go to IDLE. Sampling is mid stop bit, so a back-to-back start bit is caught.
  - rxd_s==0: pulse frame_err for one cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Deliver (same cycle as the stop sample):
  - If rx_valid==0, or rx_ready==1 in that cycle: load rx_data and set rx_valid=1. With rx_ready==1, the old byte is consumed and the new one loaded in the same edge, so rx_valid stays 1.
  - Else: pulse overrun for one cycle, drop the new byte, and keep the held byte unchanged.
- Handshake:
  - rx_valid clears on the edge where rx_valid && rx_ready, unless a delivery occurs in that cycle.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data never changes while rx_valid=1 except via the simultaneous consume-and-load case.
- Latency: rx_valid rises 2 + HALF + 9*CLKS_PER_BIT + 1 clocks after the rxd falling edge of the start bit. Benches check this to ±1 clock.
- Counters are sized by $clog2(CLKS_PER_BIT). No wrap occurs, because every state clears its counter at terminal count.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 8N1 with rx_ready=1 -> rx_valid pulses for exactly 1 cycle with rx_data=0xA5 at start-edge+2+8+144+1 clocks (±1); frame_err=overrun=0.
- Default params (10416); send 0x00 then 0xFF back-to-back, one stop bit each, rx_ready=1 -> two deliveries 0x00 and 0xFF, no errors, busy low between frames for at most 1 bit.
- CLKS_PER_BIT=16; drive rxd low for 5 clocks, then high -> no rx_valid, no pulses, FSM returns to IDLE (busy low) within HALF+3 clocks.
- CLKS_PER_BIT=16; send 0x3C with stop bit 0, holding rxd low 3 more bits, then high -> one frame_err pulse, rx_valid stays 0; a following 0x5A is received correctly.
- CLKS_PER_BIT=16, rx_ready=0; send 0x12 then 0x34 -> rx_data=0x12 held, rx_valid=1, one overrun pulse at the second stop sample. Then rx_ready=1 for one cycle -> rx_valid=0.
- CLKS_PER_BIT=16; assert rst for 1 cycle during data bit 4 of 0x77, then send 0x81 -> all outputs at reset values after the reset edge, no pulses from the aborted frame; 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a single-byte holding register.
// The serial line is synchronised into the clock domain, framed by a small
// FSM that samples each bit near its centre, and the finished byte is offered
// to the register interface through a valid/ready handshake. A stop bit read
// low gives one frame_err pulse. A byte that completes while the holding
// register is still full gives one overrun pulse.
module uart_rx_byte #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // Terminal counts: the start bit is checked at its centre, and every
  // following bit is sampled one full bit period after the previous sample.
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  // Very short bit periods leave no room between the centre sample and the
  // synchroniser delay, so they are refused at elaboration.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            rxd_p0;
  logic            rxd_s;

  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic            half_done;
  logic            bit_done;
  logic            stop_good;
  logic            stop_bad;

  // ---- stage p0/s: two-flop synchroniser; both flops reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_s  <= rxd_p0;
    end
  end

  // ---- frame FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- frame FSM: next-state decision from the synchronised line and counters.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rxd_s) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        // A start bit that is no longer low at its centre was a glitch.
        if (half_done) begin
          state_nxt = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at the stop-bit centre lets a back-to-back start bit be seen.
        if (bit_done) begin
          state_nxt = rxd_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before the next frame.
        if (rxd_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- frame FSM: decoded strobes and the busy flag.
  always_comb begin
    half_done = (state == S_START) && (clk_cnt == HALF_LAST);
    bit_done  = ((state == S_DATA) || (state == S_STOP)) && (clk_cnt == BIT_LAST);
    stop_good = (state == S_STOP) && bit_done && rxd_s;
    stop_bad  = (state == S_STOP) && bit_done && !rxd_s;
    busy      = (state != S_IDLE);
  end

  // Bit timing and bit index; every state clears the clock counter at its
  // terminal count, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_START: begin
          clk_cnt <= half_done ? '0 : clk_cnt + 1'b1;
          bit_idx <= '0;
        end
        S_DATA: begin
          clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
          if (bit_done) begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
        end
        default: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // Data bits arrive LSB first, so each sample enters at the MSB end.
  always_ff @(posedge clk) begin
    if ((state == S_DATA) && bit_done) begin
      shreg <= {rxd_s, shreg[7:1]};
    end
  end

  // Holding register, handshake and error pulses. A delivery takes
  // precedence over a plain consume, so consume-and-load keeps rx_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte with a short bit period. Frames are described at
// the byte level; a reference model turns each frame into the event it should
// produce (byte delivered, framing error or overrun) and queues it, and a
// monitor pops and compares whenever the DUT shows one of those events.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_loads  = 0;
  int   load_cyc = 0;
  evt_t sb_q[$];
  bit   model_full = 0;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: what a frame should produce, from the byte-level rules.
  task automatic model_frame(input logic [7:0] b, input bit stop_bit);
    evt_t e;
    e.data = b;
    if (!stop_bit) begin
      e.kind = EV_FERR;
    end else if (model_full && !rx_ready) begin
      e.kind = EV_OVR;
    end else begin
      e.kind = EV_BYTE;
      model_full = !rx_ready;
    end
    sb_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one 8N1 frame; extra_low keeps the line low after a bad stop bit,
  // gap adds idle-high bit periods afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input int extra_low, input int gap);
    model_frame(b, stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    for (int i = 0; i < extra_low; i++) drive_bit(1'b0);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
    rxd = 1'b1;
  endtask

  task automatic expect_evt(input int kind, input logic [7:0] d);
    evt_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event kind %0d data %0h, expected none", kind, d);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == EV_BYTE && e.kind == EV_BYTE) chk("sb_data", d, e.data);
    end
  endtask

  // Monitor: a load is a rising rx_valid, or rx_valid still high after a
  // consume on the previous edge.
  bit prev_valid  = 0;
  bit prev_accept = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 0;
      prev_accept = 0;
    end else begin
      if (rx_valid && (!prev_valid || prev_accept)) begin
        n_loads++;
        load_cyc = cyc;
        expect_evt(EV_BYTE, rx_data);
      end
      if (frame_err) expect_evt(EV_FERR, 8'h00);
      if (overrun)   expect_evt(EV_OVR, 8'h00);
      prev_valid  = rx_valid;
      prev_accept = rx_valid && rx_ready;
    end
  end

  initial begin
    int   e_cyc;
    int   loads0;
    bit   seen;
    bit   saw_busy;
    logic [7:0] b;

    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Single frame 0xA5: latency and single-cycle valid with ready high.
    loads0 = n_loads;
    e_cyc  = cyc;
    fork
      send_frame(8'hA5, 1'b1, 0, 1);
    join_none
    seen = 0;
    for (int i = 0; i < LAT + 20 && !seen; i++) begin
      @(negedge clk);
      if (n_loads != loads0) seen = 1;
    end
    chk("a5_delivered", seen, 1'b1);
    chk_range("a5_latency", load_cyc - e_cyc, LAT - 1, LAT + 1);
    chk("a5_data", rx_data, 8'hA5);
    @(negedge clk);
    chk("a5_valid_one_cycle", rx_valid, 1'b0);
    wait fork;
    repeat (CPB) @(posedge clk);
    #1;

    // Back-to-back 0x00 then 0xFF, one stop bit each.
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 1);

    // Start-bit glitch: five clocks low.
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd = 1'b1;
    saw_busy = 0;
    for (int i = 0; i < HALF + 3 - 5; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    @(negedge clk);
    chk("glitch_busy_seen", saw_busy, 1'b1);
    chk("glitch_busy_low", busy, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_valid", rx_valid, 1'b0);
    @(posedge clk);
    #1;

    // Bad stop bit with the line held low, then a good frame.
    send_frame(8'h3C, 1'b0, 3, 1);
    @(negedge clk);
    chk("ferr_no_valid", rx_valid, 1'b0);
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 0, 1);

    // Overrun: consumer stalled for two frames.
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, 0, 0);
    send_frame(8'h34, 1'b1, 0, 1);
    @(negedge clk);
    chk("ovr_valid_held", rx_valid, 1'b1);
    chk("ovr_data_held", rx_data, 8'h12);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    model_full = 0;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_consumed", rx_valid, 1'b0);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;

    // Reset during data bit 4 of 0x77, then 0x81. Nothing is queued for the
    // aborted frame, so any event from it shows up in the scoreboard.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h77 >> i));
    rxd = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_rx_valid", rx_valid, 1'b0);
    chk("abort_frame_err", frame_err, 1'b0);
    chk("abort_overrun", overrun, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, 0, 1);
    @(negedge clk);
    chk("abort_then_81", rx_data, 8'h81);
    @(posedge clk);
    #1;

    // Randomised frames: random bytes, gaps, bad stop bits and ready.
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0, $urandom_range(0, 2), 1);
      end else begin
        send_frame(b, 1'b1, 0, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        rx_ready = ~rx_ready;
        if (rx_ready) begin
          // One edge with ready high drains any held byte.
          model_full = 0;
        end
      end
    end
    rx_ready = 1'b1;
    model_full = 0;
    repeat (2 * CPB) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the run always ends on its own.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL timeout: got %0d cycles, expected completion", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
